// File: rtl/integer_rf_unit_if.sv
// Register-file access bundle: one write port from write-back, two decode read ports.
interface integer_rf_unit_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) ();
    logic            wr_en_in;
    logic            flush_in;
    logic [AW-1:0]   rd_addr_in;
    logic [XLEN-1:0] rd_in;
    logic [AW-1:0]   rs_1_addr_in;
    logic [AW-1:0]   rs_2_addr_in;
    logic [XLEN-1:0] rs_1_out;
    logic [XLEN-1:0] rs_2_out;

    // Pipeline side: drives the write and read addresses, consumes read data.
    modport master (
        output wr_en_in,
        output flush_in,
        output rd_addr_in,
        output rd_in,
        output rs_1_addr_in,
        output rs_2_addr_in,
        input  rs_1_out,
        input  rs_2_out
    );

    // Register-file side.
    modport slave (
        input  wr_en_in,
        input  flush_in,
        input  rd_addr_in,
        input  rd_in,
        input  rs_1_addr_in,
        input  rs_2_addr_in,
        output rs_1_out,
        output rs_2_out
    );
endinterface

// File: rtl/integer_rf_unit.sv
// RV32I integer register file: x0 hardwired to zero, one synchronous write port,
// two combinational read ports with same-cycle write-through bypass.
module integer_rf_unit #(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     NREGS   = 32,
    parameter logic [XLEN-1:0] RST_VAL = '0
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    integer_rf_unit_if.slave   rf
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_commit;
    logic            bypass_en;

    // Flush and x0 both kill the write; the bypass follows the same qualifier.
    assign wr_commit = rf.wr_en_in & ~rf.flush_in & (rf.rd_addr_in != '0);
    // No forwarding while reset is asserted so reads return the reset contents.
    assign bypass_en = wr_commit & rst_n_in;

    // Register storage; entry 0 is held at zero and never written.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == 0) ? '0 : RST_VAL;
            end
        end else if (wr_commit) begin
            regs[rf.rd_addr_in] <= rf.rd_in;
        end
    end

    // Source 1 read: x0 forced to zero, then bypass, then stored value.
    always_comb begin
        rf.rs_1_out = regs[rf.rs_1_addr_in];
        if (rf.rs_1_addr_in == '0) begin
            rf.rs_1_out = '0;
        end else if (bypass_en && (rf.rs_1_addr_in == rf.rd_addr_in)) begin
            rf.rs_1_out = rf.rd_in;
        end
    end

    // Source 2 read: same priority as source 1.
    always_comb begin
        rf.rs_2_out = regs[rf.rs_2_addr_in];
        if (rf.rs_2_addr_in == '0) begin
            rf.rs_2_out = '0;
        end else if (bypass_en && (rf.rs_2_addr_in == rf.rd_addr_in)) begin
            rf.rs_2_out = rf.rd_in;
        end
    end

endmodule
